mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, memory address width.
REQ-002 SHALL provide parameter DATA_W, default 32, memory data width.
REQ-003 SHALL provide port clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL provide port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL provide port ifu_req_valid  in  1  fetch request pending.
REQ-006 SHALL provide port ifu_req_ready  out  1  fetch request accepted this cycle.
REQ-007 SHALL provide port ifu_req_addr  in  ADDR_W  fetch address.
REQ-008 SHALL provide port ifu_resp_valid  out  1  fetch data valid (one-cycle pulse).
REQ-009 SHALL provide port ifu_resp_rdata  out  DATA_W  fetched instruction word.
REQ-010 SHALL provide port lsu_req_valid  in  1  load/store request pending.
REQ-011 SHALL provide port lsu_req_ready  out  1  load/store request accepted this cycle.
REQ-012 SHALL provide port lsu_req_addr  in  ADDR_W  load/store address.
REQ-013 SHALL provide port lsu_req_wen  in  1  1 = store, 0 = load.
REQ-014 SHALL provide port lsu_req_wdata  in  DATA_W  store data.
REQ-015 SHALL provide port lsu_req_wmask  in  8  store byte mask.
REQ-016 SHALL provide port lsu_resp_valid  out  1  load data / store ack valid (one-cycle pulse).
REQ-017 SHALL provide port lsu_resp_rdata  out  DATA_W  load data.
REQ-018 SHALL provide port mem_req_valid  out  1  downstream request valid.
REQ-019 SHALL provide port mem_req_ready  in  1  downstream accepts request.
REQ-020 SHALL provide port mem_req_addr  out  ADDR_W  downstream address.
REQ-021 SHALL provide port mem_req_wen  out  1  downstream write enable (0 for IFU).
REQ-022 SHALL provide port mem_req_wdata  out  DATA_W  downstream write data.
REQ-023 SHALL provide port mem_req_wmask  out  8  downstream byte mask (8'h00 for IFU).
REQ-024 SHALL provide port mem_resp_valid  in  1  downstream response valid.
REQ-025 SHALL provide port mem_resp_rdata  in  DATA_W  downstream read data.

Function
REQ-026 SHALL implement FSM states IDLE, REQ, RESP with exactly one transaction outstanding.
REQ-027 In IDLE, with any req_valid high, SHALL pulse the winner's req_ready, latch its addr/wen/wdata/wmask and owner, and enter REQ next cycle.
REQ-028 In REQ, SHALL hold mem_req_valid and latched fields stable until mem_req_valid & mem_req_ready, then enter RESP.
REQ-029 In RESP, on mem_resp_valid SHALL drive owner resp_valid=1 and resp_rdata=mem_resp_rdata combinationally, then return to IDLE.
REQ-030 Non-owner resp_valid SHALL be 0 always; req_ready SHALL be 0 outside IDLE; mem_resp_valid outside RESP SHALL be ignored.
REQ-031 Minimum latency SHALL be: accept cycle N, mem_req_valid from N+1, resp_valid at N+2 earliest; one IDLE bubble between transactions.
REQ-032 Requester fields or valid changing after acceptance SHALL NOT affect the latched transaction.
REQ-033 Without round-robin, simultaneous IFU and LSU requests SHALL grant LSU.

Reset
REQ-034 On rst low, SHALL enter IDLE, abandon any transaction, force all outputs 0, and clear last-grant to IFU, independent of clk.

Configuration
REQ-035 With YSYX_23060059_ARB_RR_EN defined, simultaneous requests SHALL grant the requester not granted last; without it, REQ-033 fixed priority SHALL apply.

Structure
REQ-036 State enum and owner encodings (OWN_IFU=0, OWN_LSU=1) SHALL live in the shared package; grant selection SHALL be sub-module mem_arb_pick.

Verification
REQ-037 IFU-only read 0x80000000, mem_req_ready=1, resp 1 cycle later with 0x00000413 -> ifu_resp_valid pulse, rdata 0x00000413, lsu_resp_valid 0.
REQ-038 Both request same IDLE cycle (LSU store 0x80001000, wdata 0xDEADBEEF, wmask 0x0F) -> LSU served first; without macro LSU wins again if re-requesting, with macro IFU wins next.
REQ-039 mem_req_ready low 5 cycles -> mem_req_valid and all fields stable 5 cycles, accepted cycle 6.
REQ-040 rst low during RESP -> outputs 0 immediately, late mem_resp_valid produces no requester resp_valid, next request served normally.
REQ-041 IFU drops valid and changes addr after acceptance -> downstream still sees original address, single response returned.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states and requester owner encoding.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

    localparam int WMASK_W = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between IFU and LSU. Fixed LSU priority by default;
// defining YSYX_23060059_ARB_RR_EN alternates grants on simultaneous requests.
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    input  owner_e last_owner,
    output logic   grant_valid,
    output owner_e grant_owner
);

`ifndef YSYX_23060059_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

    always_comb begin
        grant_valid = ifu_valid | lsu_valid;
        grant_owner = OWN_IFU;
        if (ifu_valid && lsu_valid) begin
`ifdef YSYX_23060059_ARB_RR_EN
            grant_owner = (last_owner == OWN_LSU) ? OWN_IFU : OWN_LSU;
`else
            grant_owner = OWN_LSU;
`endif
        end else if (lsu_valid) begin
            grant_owner = OWN_LSU;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between IFU and LSU.
// Optional round-robin on simultaneous requests via YSYX_23060059_ARB_RR_EN.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ifu_req_valid,
    output logic               ifu_req_ready,
    input  logic [ADDR_W-1:0]  ifu_req_addr,
    output logic               ifu_resp_valid,
    output logic [DATA_W-1:0]  ifu_resp_rdata,
    input  logic               lsu_req_valid,
    output logic               lsu_req_ready,
    input  logic [ADDR_W-1:0]  lsu_req_addr,
    input  logic               lsu_req_wen,
    input  logic [DATA_W-1:0]  lsu_req_wdata,
    input  logic [7:0]         lsu_req_wmask,
    output logic               lsu_resp_valid,
    output logic [DATA_W-1:0]  lsu_resp_rdata,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    output logic               mem_req_wen,
    output logic [DATA_W-1:0]  mem_req_wdata,
    output logic [7:0]         mem_req_wmask,
    input  logic               mem_resp_valid,
    input  logic [DATA_W-1:0]  mem_resp_rdata
);

    arb_state_e          state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [WMASK_W-1:0]  wmask_q, wmask_d;

    logic   grant_valid;
    owner_e grant_owner;
    logic   accept;
    logic   resp_fire;

    mem_arb_pick u_pick (
        .ifu_valid   (ifu_req_valid),
        .lsu_valid   (lsu_req_valid),
        .last_owner  (last_q),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    // rst gates the accept path so ready stays low while reset is asserted
    assign accept = rst && (state_q == IDLE) && grant_valid;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = REQ;
                    owner_d = grant_owner;
                    last_d  = grant_owner;
                    if (grant_owner == OWN_LSU) begin
                        addr_d  = lsu_req_addr;
                        wen_d   = lsu_req_wen;
                        wdata_d = lsu_req_wdata;
                        wmask_d = lsu_req_wmask;
                    end else begin
                        addr_d  = ifu_req_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wmask_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_req_ready) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (mem_resp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_IFU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    // Payload needs no reset: it only reaches the outputs while in REQ
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wen_q   <= wen_d;
        wdata_q <= wdata_d;
        wmask_q <= wmask_d;
    end

    assign ifu_req_ready = accept && (grant_owner == OWN_IFU);
    assign lsu_req_ready = accept && (grant_owner == OWN_LSU);

    assign mem_req_valid = (state_q == REQ);
    assign mem_req_addr  = mem_req_valid ? addr_q  : '0;
    assign mem_req_wen   = mem_req_valid && wen_q;
    assign mem_req_wdata = mem_req_valid ? wdata_q : '0;
    assign mem_req_wmask = mem_req_valid ? wmask_q : '0;

    assign resp_fire      = (state_q == RESP) && mem_resp_valid;
    assign ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
    assign lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
    assign ifu_resp_rdata = ifu_resp_valid ? mem_resp_rdata : '0;
    assign lsu_resp_rdata = lsu_resp_valid ? mem_resp_rdata : '0;

endmodule
